uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8-bit, 9600-baud serial transmit block. It adds the following over the previous generation:
- configurable data width and bit period;
- a transmit FIFO with a valid/ready input handshake;
- runtime parity (none/even/odd) and 1 or 2 stop bits;
- correct idle-high stop bits;
- a busy flag.

It sits between the LC3 memory-mapped UART data register and the board txd pin.

Parameters:
- DATA_W, 8, data bits per frame, legal 5..9.
- CLKS_PER_BIT, 868, clk cycles per serial bit, >=2.
- DEPTH, 4, FIFO entries, power of two, >=2.
- CNT_W, $clog2(DEPTH+1), width of fifo_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- tx_data  in  DATA_W  word to transmit, sent LSB first.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  FIFO can accept a word.
- parity_en  in  1  1 = parity bit inserted.
- parity_odd  in  1  1 = odd parity, 0 = even.
- two_stop  in  1  1 = two stop bits.
- txd  out  1  serial line, idle high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_count  out  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at a rising edge) forces the following at the next edge:
  - txd=1, busy=0, tx_ready=1, fifo_count=0;
  - FIFO pointers cleared; state IDLE; bit counter and baud counter 0.
  - Reset in mid-frame aborts the frame immediately: txd=1 on the next edge and queued data is discarded.
- Handshake:
  - Write occurs when tx_valid & tx_ready at a rising edge.
  - tx_ready = (fifo_count != DEPTH) and is a registered-state function only; it does not depend on tx_valid.
  - A push while full is impossible. A same-cycle pop does not open the slot until the next cycle.
- Simultaneous push and pop: count is unchanged and both take effect.
- FIFO has no bypass path.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into the shift register, latch parity_en/parity_odd/two_stop for the whole frame, clear the baud counter, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, shifting right. After DATA_W bits go to PARITY if the latched parity_en, else STOP.
  - PARITY: txd = XOR of the data bits XOR latched parity_odd, for CLKS_PER_BIT cycles.
  - STOP: txd=1 for CLKS_PER_BIT cycles (2*CLKS_PER_BIT if two_stop latched).
    - Then, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap).
    - Else go to IDLE.
- Latency: a word written at edge N into an empty FIFO with the state machine in IDLE drives txd=0 from edge N+2.
- Bit timing: every bit lasts exactly CLKS_PER_BIT clk cycles. The baud counter runs 0..CLKS_PER_BIT-1 and restarts at each frame start (no free-running phase error).
- Frame length: 1 + DATA_W + parity_en + (1 or 2) bits.
- Config changes mid-frame have no effect on the current frame.
- busy = (state != IDLE) | (fifo_count != 0), registered.
- txd is driven directly from a flop (glitch-free).

Decomposition:
- Package uart_pkg: state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and the parity-mode encoding shared with the future receiver.
- One sub-module: sync_fifo (DATA_W x DEPTH, synchronous reset, count output). The baud counter and FSM stay in the top level.

Test Plan:
1. CLKS_PER_BIT=4, DATA_W=8, parity off, 1 stop. Write 8'hA5 at edge N.
   - txd low from N+2 for 4 cycles.
   - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
   - Then high for 4 cycles; busy falls after the stop bit; 40-cycle frame.
2. Parity even, then odd, on 8'h03.
   - Parity bit is 0 (even) / 1 (odd).
   - 8'h07 gives 1 / 0.
   - two_stop=1 extends the high period to 8 cycles.
3. DEPTH=4, tx_valid held with 6 words while a frame is in progress.
   - tx_ready drops when fifo_count=4.
   - All 6 words are transmitted in order, back to back, with no idle between stop and next start.
4. Simultaneous push and pop when fifo_count=2: count stays 2 and the order is preserved.
5. Assert rst in the middle of DATA.
   - Next edge: txd=1, fifo_count=0, busy=0, tx_ready=1.
   - No further start bit until a new write.
6. Toggle parity_en and two_stop during a frame: the current frame keeps its latched settings and the next frame uses the new ones.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the parity-mode encoding
// used by both the transmitter and the planned receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } par_mode_t;

  function automatic par_mode_t par_mode(input logic en, input logic odd);
    if (!en) return PAR_NONE;
    return odd ? PAR_ODD : PAR_EVEN;
  endfunction

  // data_xor is the XOR of all data bits; even parity repeats it, odd inverts it
  function automatic logic par_bit(input par_mode_t mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, DATA_W x DEPTH, registered count; read data is the head, valid while not empty.
// Latency: a push is visible at the head one cycle later; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop_vld,
  output logic [DATA_W-1:0] pop_dat,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push_vld & ~full;
  assign pop_ok  = pop_vld & ~empty;
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO; a write into an empty FIFO while idle drives the start bit two edges later.
// tx_ready falls only when the FIFO is full; frames run back to back while words are queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 4,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  output logic              txd,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  par_mode_t         mode_q, mode_d;
  logic              two_stop_q, two_stop_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;

  logic              push;
  logic              pop;
  logic              load;
  logic              baud_end;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dat;
  logic [CNT_W-1:0]  cnt_nxt;

  assign tx_ready = ~fifo_full;
  assign push     = tx_valid & tx_ready;
  assign baud_end = (baud_q == BAUD_LAST);
  assign txd      = txd_q;
  assign busy     = busy_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push),
    .push_dat (tx_data),
    .pop_vld  (pop),
    .pop_dat  (fifo_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    mode_d     = mode_q;
    two_stop_d = two_stop_q;
    load       = 1'b0;
    pop        = 1'b0;

    if (state_q != ST_IDLE) baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (baud_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (mode_q != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (baud_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // bit_q counts stop bits here so the baud counter keeps its 0..CLKS_PER_BIT-1 range
        if (baud_end) begin
          if (two_stop_q && bit_q == '0) begin
            bit_d = BIT_W'(1);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      pop        = 1'b1;
      shift_d    = fifo_dat;
      mode_d     = par_mode(parity_en, parity_odd);
      par_d      = par_bit(par_mode(parity_en, parity_odd), ^fifo_dat);
      two_stop_d = two_stop;
      baud_d     = '0;
      bit_d      = '0;
      state_d    = ST_START;
    end

    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
      ST_PARITY: txd_d = par_q;
      default:   txd_d = 1'b1;
    endcase

    cnt_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
    busy_d  = (state_d != ST_IDLE) | (cnt_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      mode_q     <= PAR_NONE;
      two_stop_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      mode_q     <= mode_d;
      two_stop_q <= two_stop_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

endmodule
